// File: rtl/mandelbrot_pixel_sink.sv
// Mandelbrot pixel sink: steps the engine through one frame pixel by pixel,
// packs pairs of 4-bit iteration counts into bytes and streams them out
// through a small first-word-fall-through FIFO with frame start/end markers.
module mandelbrot_pixel_sink #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       eng_run,
  input  logic       eng_running,
  input  logic [3:0] eng_ctr,
  input  logic       eng_finished,
  output logic [7:0] tdata,
  output logic       tvalid,
  input  logic       tready,
  output logic       tuser,
  output logic       tlast,
  output logic       busy,
  output logic       frame_done,
  output logic       sync_err
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_DONE,
    CAPTURE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          half;
  logic [3:0]    hi_nib;
  logic          last_pix;
  logic          first_byte;
  logic          push;
  logic          pop;

  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [9:0]    head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign last_pix   = (x == X_LAST) && (y == Y_LAST);
  assign first_byte = (x == XW'(1)) && (y == '0);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state strobes; a second pixel is only started when
  // the FIFO has room, so the push at its capture can never overflow.
  always_comb begin
    state_nxt  = state;
    eng_run    = 1'b0;
    push       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = CHECK;
      end
      CHECK: begin
        if (!half || (count < CNT_FULL)) state_nxt = ISSUE;
      end
      ISSUE: begin
        eng_run = 1'b1;
        if (eng_running) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!eng_running) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        push = half;
        if (last_pix) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = CHECK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel position and pair-half tracking; cleared when a frame starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      half <= 1'b0;
    end else if (state == IDLE) begin
      if (enable) begin
        x    <= '0;
        y    <= '0;
        half <= 1'b0;
      end
    end else if (state == CAPTURE) begin
      half <= ~half;
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // First pixel of a pair is held until its partner arrives.
  always_ff @(posedge clk) begin
    if ((state == CAPTURE) && !half) hi_nib <= eng_ctr;
  end

  // Sticky flag: engine end-of-frame must coincide with our last pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if ((state == CAPTURE) && (eng_finished != last_pix)) begin
      sync_err <= 1'b1;
    end
  end

  assign pop = tvalid && tready;

  // FIFO control: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {byte, frame-start, frame-end}.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {hi_nib, eng_ctr, first_byte, last_pix};
  end

  // Head is read combinationally; outputs are forced to zero while empty so
  // stale or uninitialised storage never reaches the stream.
  assign head   = fifo_mem[rd_ptr];
  assign tvalid = (count != '0);
  assign tdata  = tvalid ? head[9:2] : 8'h00;
  assign tuser  = tvalid & head[1];
  assign tlast  = tvalid & head[0];

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
`timescale 1ns/1ps
// Directed bench for mandelbrot_pixel_sink with a behavioural engine model.
module tb_mandelbrot_pixel_sink;

  localparam int W    = 8;
  localparam int H    = 2;
  localparam int FD   = 4;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       tready = 1'b0;
  logic       eng_running = 1'b0;
  logic       eng_finished = 1'b0;
  logic [3:0] eng_ctr = 4'h0;
  logic       eng_run;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tuser;
  logic       tlast;
  logic       busy;
  logic       frame_done;
  logic       sync_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // engine model knobs (bench-owned) and state (model-owned)
  int lat = 1;
  int run_delay = 0;
  int fin_idx = NPIX - 1;
  int e_pix = 0;
  int e_cnt = 0;
  int e_phase = 0;
  int p1_drop = 0;

  // monitor state (monitor-owned, cumulative)
  logic [9:0] rec [256];
  int   nrec = 0;
  int   fd_cnt = 0;
  int   run_hi = 0;
  int   bb_low = 0;
  int   first_rise = 0;
  logic armed = 1'b1;
  logic mon_bb = 1'b0;

  mandelbrot_pixel_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .eng_run(eng_run), .eng_running(eng_running), .eng_ctr(eng_ctr),
    .eng_finished(eng_finished),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tuser(tuser), .tlast(tlast),
    .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine: waits run_delay cycles before acknowledging, stays busy lat
  // cycles showing a wrong count, then drops busy with ctr = pixel index.
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_running  = 1'b0;
      eng_finished = 1'b0;
      eng_ctr      = 4'h0;
      e_pix        = 0;
      e_cnt        = 0;
      e_phase      = 0;
    end else if (e_phase == 0) begin
      if (eng_run) begin
        if (e_cnt < run_delay) begin
          e_cnt++;
        end else begin
          eng_running  = 1'b1;
          eng_ctr      = ~4'(e_pix);
          eng_finished = 1'b0;
          e_cnt        = 1;
          e_phase      = 1;
        end
      end
    end else if (e_cnt < lat) begin
      e_cnt++;
    end else begin
      eng_running  = 1'b0;
      eng_ctr      = 4'(e_pix);
      eng_finished = ((e_pix % NPIX) == fin_idx);
      if ((e_pix % NPIX) == 1) p1_drop = cyc;
      e_pix++;
      e_cnt   = 0;
      e_phase = 0;
    end
  end

  // Stream / status monitor.
  always @(negedge clk) begin
    if (tvalid && tready && nrec < 256) begin
      rec[nrec] = {tdata, tuser, tlast};
      nrec++;
    end
    if (frame_done) fd_cnt++;
    if (eng_run) run_hi++;
    if (mon_bb && !busy) bb_low++;
    if (!rst_n) armed = 1'b1;
    else if (armed && tvalid) begin
      first_rise = cyc;
      armed = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_timeout"}, 32'(k >= budget), 32'd0);
  endtask

  // One frame with pixel i -> ctr i: bytes 0x01, 0x23, ... 0xEF.
  task automatic check_frame(input int base, input string tag);
    logic [9:0] exp;
    for (int k = 0; k < NPIX / 2; k++) begin
      exp = {4'(2 * k), 4'(2 * k + 1), (k == 0), (k == NPIX / 2 - 1)};
      chk($sformatf("%s_b%0d", tag, k), 32'(rec[base + k]), 32'(exp));
    end
  endtask

  initial begin
    int base;
    int fdb;
    int rh;
    int bl;
    int k;

    // reset values
    rst_n  = 1'b0;
    tready = 1'b0;
    tick(2);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_tuser", 32'(tuser), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_eng_run", 32'(eng_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // basic frame, 1-cycle engine, free-flowing stream
    lat = 1; run_delay = 0; fin_idx = NPIX - 1; tready = 1'b1;
    base = nrec; fdb = fd_cnt;
    pulse_enable();
    wait_idle("t1", 500);
    tick(4);
    chk("t1_nbytes", 32'(nrec - base), 32'd8);
    check_frame(base, "t1");
    chk("t1_frame_done", 32'(fd_cnt - fdb), 32'd1);
    chk("t1_sync_err", 32'(sync_err), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_tvalid_drained", 32'(tvalid), 32'd0);
    chk("t1_latency", 32'(first_rise - p1_drop), 32'd2);

    // back-pressure: FIFO fills after 4 bytes, stall before the 10th pixel
    do_reset();
    tready = 1'b0; lat = 2;
    base = nrec;
    pulse_enable();
    tick(150);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_eng_run", 32'(eng_run), 32'd0);
    chk("t2_pixels", 32'(e_pix), 32'd9);
    chk("t2_tvalid", 32'(tvalid), 32'd1);
    chk("t2_head", 32'({tdata, tuser, tlast}), 32'h006);
    rh = run_hi;
    tick(40);
    chk("t2_no_run", 32'(run_hi - rh), 32'd0);
    chk("t2_head_stable", 32'({tdata, tuser, tlast}), 32'h006);
    tready = 1'b1;
    wait_idle("t2", 500);
    tick(6);
    chk("t2_nbytes", 32'(nrec - base), 32'd8);
    check_frame(base, "t2");

    // slow acknowledge and 128-cycle pixels
    do_reset();
    lat = 128; run_delay = 3;
    base = nrec;
    pulse_enable();
    k = 0;
    while (!eng_run && k < 20) begin
      tick(1);
      k++;
    end
    chk("t3_run_timeout", 32'(k >= 20), 32'd0);
    tick(2);
    chk("t3_run_held", 32'(eng_run), 32'd1);
    chk("t3_not_running", 32'(eng_running), 32'd0);
    wait_idle("t3", 3000);
    tick(4);
    run_delay = 0;
    chk("t3_nbytes", 32'(nrec - base), 32'd8);
    check_frame(base, "t3");

    // engine flags end-of-frame early: sticky sync_err
    do_reset();
    lat = 1; fin_idx = 2;
    fdb = fd_cnt;
    pulse_enable();
    wait_idle("t4", 500);
    tick(3);
    chk("t4_sync_err", 32'(sync_err), 32'd1);
    chk("t4_frame_done", 32'(fd_cnt - fdb), 32'd1);
    tick(10);
    chk("t4_sync_sticky", 32'(sync_err), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("t4_sync_cleared", 32'(sync_err), 32'd0);
    rst_n = 1'b1;
    tick(1);
    fin_idx = NPIX - 1;

    // reset while the 5th pixel is in flight, then a clean frame
    do_reset();
    lat = 20; tready = 1'b1;
    pulse_enable();
    k = 0;
    while (!(e_pix == 4 && eng_running) && k < 300) begin
      tick(1);
      k++;
    end
    chk("t5_wait_timeout", 32'(k >= 300), 32'd0);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("t5_rst_tvalid", 32'(tvalid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_eng_run", 32'(eng_run), 32'd0);
    rst_n = 1'b1;
    tick(1);
    lat = 1;
    base = nrec; fdb = fd_cnt;
    pulse_enable();
    wait_idle("t5", 500);
    tick(4);
    chk("t5_nbytes", 32'(nrec - base), 32'd8);
    check_frame(base, "t5");
    chk("t5_frame_done", 32'(fd_cnt - fdb), 32'd1);

    // enable held: two frames back to back with a single IDLE cycle between
    do_reset();
    lat = 1; tready = 1'b1;
    base = nrec; fdb = fd_cnt; bl = bb_low;
    enable = 1'b1;
    tick(1);
    mon_bb = 1'b1;
    k = 0;
    while ((fd_cnt - fdb) < 2 && k < 1000) begin
      tick(1);
      k++;
    end
    mon_bb = 1'b0;
    enable = 1'b0;
    chk("t6_timeout", 32'(k >= 1000), 32'd0);
    tick(6);
    chk("t6_idle_cycles", 32'(bb_low - bl), 32'd1);
    chk("t6_frame_done", 32'(fd_cnt - fdb), 32'd2);
    chk("t6_nbytes", 32'(nrec - base), 32'd16);
    check_frame(base, "t6a");
    check_frame(base + 8, "t6b");
    chk("t6_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
